// File: rtl/gomoku_pkg.sv
// Shared types and constants for the Gomoku board controller.
package gomoku_pkg;

   localparam int N_DEF       = 6;
   localparam int WIN_LEN_DEF = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BLACK = 2'b01,
      WHITE = 2'b10
   } cell_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SCAN_POS = 3'd1,
      SCAN_NEG = 3'd2,
      FINISH   = 3'd3,
      WON      = 3'd4,
      DRAW     = 3'd5
   } state_t;

   // Scan directions: 0 horizontal, 1 vertical, 2 main diagonal, 3 anti-diagonal
   localparam logic signed [1:0] DIR_DR [4] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
   localparam logic signed [1:0] DIR_DC [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

   // Stone colour for the side to move: black moves on turn 0, white on turn 1
   function automatic cell_t turn_colour(input logic turn);
      if (turn) begin
         return WHITE;
      end else begin
         return BLACK;
      end
   endfunction

endpackage

// File: rtl/board_line_probe.sv
// Combinational probe of one cell along a scan line: origin +/- k*(dr,dc).
// Reports a hit when the probed cell is on the board and holds the colour.
module board_line_probe
   import gomoku_pkg::*;
#(
   parameter  int N  = N_DEF,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0][N-1:0][1:0] board,
   input  logic [IW-1:0]            org_row,
   input  logic [IW-1:0]            org_col,
   input  logic [1:0]               dir,
   input  logic [IW:0]              k,
   input  logic                     neg,
   input  cell_t                    colour,
   output logic                     hit
);

   // Two extra bits so that -1 and N are representable and detectable
   localparam int CW = IW + 2;

   logic signed [CW-1:0] k_s;
   logic signed [CW-1:0] step_r_s;
   logic signed [CW-1:0] step_c_s;
   logic signed [CW-1:0] row_s;
   logic signed [CW-1:0] col_s;
   logic                 in_bounds_s;
   logic [1:0]           cell_s;

   // Build the signed probe coordinate for the current direction and side
   always_comb begin
      k_s = $signed({1'b0, k});
      if (DIR_DR[dir] == 2'sd0) begin
         step_r_s = '0;
      end else if (DIR_DR[dir] == 2'sd1) begin
         step_r_s = k_s;
      end else begin
         step_r_s = -k_s;
      end
      if (DIR_DC[dir] == 2'sd0) begin
         step_c_s = '0;
      end else if (DIR_DC[dir] == 2'sd1) begin
         step_c_s = k_s;
      end else begin
         step_c_s = -k_s;
      end
      if (neg) begin
         row_s = $signed({2'b00, org_row}) - step_r_s;
         col_s = $signed({2'b00, org_col}) - step_c_s;
      end else begin
         row_s = $signed({2'b00, org_row}) + step_r_s;
         col_s = $signed({2'b00, org_col}) + step_c_s;
      end
   end

   // Bounds check and cell fetch; off-board coordinates never match a cell
   always_comb begin
      in_bounds_s = !row_s[CW-1] && !col_s[CW-1] &&
                    (row_s < $signed(CW'(N))) && (col_s < $signed(CW'(N)));
      cell_s = 2'b00;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if ((row_s == $signed(CW'(r))) && (col_s == $signed(CW'(c)))) begin
               cell_s = board[r][c];
            end else begin
               cell_s = cell_s;
            end
         end
      end
      hit = in_bounds_s && (cell_s == colour);
   end

endmodule

// File: rtl/board_ctrl.sv
// Gomoku game controller: owns the board, sequences placements and runs a
// per-cycle line scan after each accepted stone to detect a win or a draw.
module board_ctrl
   import gomoku_pkg::*;
#(
   parameter  int N       = N_DEF,
   parameter  int WIN_LEN = WIN_LEN_DEF,
   localparam int IW      = $clog2(N)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     new_game,
   input  logic                     mv_up,
   input  logic                     mv_down,
   input  logic                     mv_left,
   input  logic                     mv_right,
   input  logic                     place,
   output logic [N-1:0][N-1:0][1:0] board,
   output logic [IW-1:0]            cur_row,
   output logic [IW-1:0]            cur_col,
   output logic                     turn,
   output logic                     busy,
   output logic                     game_over,
   output logic [1:0]               winner,
   output logic                     place_rej
);

   localparam int MW  = $clog2(N * N + 1);
   localparam int CNW = $clog2(WIN_LEN + 1);

   state_t                    state_r, state_n;
   logic [N-1:0][N-1:0][1:0]  board_r, board_n;
   logic [IW-1:0]             cur_row_r, cur_row_n;
   logic [IW-1:0]             cur_col_r, cur_col_n;
   logic                      turn_r, turn_n;
   logic [MW-1:0]             moves_r, moves_n;
   logic [IW-1:0]             org_row_r, org_row_n;
   logic [IW-1:0]             org_col_r, org_col_n;
   cell_t                     colour_r, colour_n;
   logic [1:0]                dir_r, dir_n;
   logic [IW:0]               k_r, k_n;
   logic [CNW-1:0]            count_r, count_n;
   logic                      busy_r, busy_n;
   logic                      game_over_r, game_over_n;
   logic [1:0]                winner_r, winner_n;
   logic                      place_rej_r, place_rej_n;
   logic                      hit_s;

   board_line_probe #(.N(N)) u_probe (
      .board   (board_r),
      .org_row (org_row_r),
      .org_col (org_col_r),
      .dir     (dir_r),
      .k       (k_r),
      .neg     (state_r == SCAN_NEG),
      .colour  (colour_r),
      .hit     (hit_s)
   );

   // Next-state, board update and registered-output decode
   always_comb begin
      state_n     = state_r;
      board_n     = board_r;
      cur_row_n   = cur_row_r;
      cur_col_n   = cur_col_r;
      turn_n      = turn_r;
      moves_n     = moves_r;
      org_row_n   = org_row_r;
      org_col_n   = org_col_r;
      colour_n    = colour_r;
      dir_n       = dir_r;
      k_n         = k_r;
      count_n     = count_r;
      place_rej_n = 1'b0;

      case (state_r)
         IDLE: begin
            if (place) begin
               if (board_r[cur_row_r][cur_col_r] != 2'b00) begin
                  place_rej_n = 1'b1;
               end else begin
                  board_n[cur_row_r][cur_col_r] = turn_colour(turn_r);
                  colour_n  = turn_colour(turn_r);
                  org_row_n = cur_row_r;
                  org_col_n = cur_col_r;
                  moves_n   = moves_r + MW'(1);
                  dir_n     = 2'd0;
                  k_n       = (IW+1)'(1);
                  count_n   = CNW'(1);
                  state_n   = SCAN_POS;
               end
            end else if (mv_up) begin
               cur_row_n = (cur_row_r == '0) ? IW'(N - 1) : cur_row_r - IW'(1);
            end else if (mv_down) begin
               cur_row_n = (cur_row_r == IW'(N - 1)) ? '0 : cur_row_r + IW'(1);
            end else if (mv_left) begin
               cur_col_n = (cur_col_r == '0) ? IW'(N - 1) : cur_col_r - IW'(1);
            end else if (mv_right) begin
               cur_col_n = (cur_col_r == IW'(N - 1)) ? '0 : cur_col_r + IW'(1);
            end else begin
               state_n = IDLE;
            end
         end

         SCAN_POS, SCAN_NEG: begin
            if (hit_s) begin
               if ((count_r + CNW'(1)) >= CNW'(WIN_LEN)) begin
                  count_n = CNW'(WIN_LEN);
                  state_n = WON;
               end else begin
                  count_n = count_r + CNW'(1);
                  k_n     = k_r + (IW+1)'(1);
               end
            end else if (state_r == SCAN_POS) begin
               k_n     = (IW+1)'(1);
               state_n = SCAN_NEG;
            end else if (dir_r != 2'd3) begin
               dir_n   = dir_r + 2'd1;
               k_n     = (IW+1)'(1);
               count_n = CNW'(1);
               state_n = SCAN_POS;
            end else begin
               state_n = FINISH;
            end
         end

         FINISH: begin
            if (moves_r == MW'(N * N)) begin
               state_n = DRAW;
            end else begin
               turn_n  = ~turn_r;
               state_n = IDLE;
            end
         end

         WON: begin
            state_n = WON;
         end

         DRAW: begin
            state_n = DRAW;
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      // A new game wins over everything, including a scan in flight
      if (new_game) begin
         state_n     = IDLE;
         board_n     = '0;
         cur_row_n   = '0;
         cur_col_n   = '0;
         turn_n      = 1'b0;
         moves_n     = '0;
         org_row_n   = '0;
         org_col_n   = '0;
         colour_n    = BLACK;
         dir_n       = 2'd0;
         k_n         = (IW+1)'(1);
         count_n     = CNW'(1);
         place_rej_n = 1'b0;
      end else begin
         place_rej_n = place_rej_n;
      end

      busy_n      = (state_n == SCAN_POS) || (state_n == SCAN_NEG) || (state_n == FINISH);
      game_over_n = (state_n == WON) || (state_n == DRAW);
      winner_n    = (state_n == WON) ? colour_n : EMPTY;
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         board_r     <= '0;
         cur_row_r   <= '0;
         cur_col_r   <= '0;
         turn_r      <= 1'b0;
         moves_r     <= '0;
         org_row_r   <= '0;
         org_col_r   <= '0;
         colour_r    <= BLACK;
         dir_r       <= 2'd0;
         k_r         <= (IW+1)'(1);
         count_r     <= CNW'(1);
         busy_r      <= 1'b0;
         game_over_r <= 1'b0;
         winner_r    <= 2'b00;
         place_rej_r <= 1'b0;
      end else begin
         state_r     <= state_n;
         board_r     <= board_n;
         cur_row_r   <= cur_row_n;
         cur_col_r   <= cur_col_n;
         turn_r      <= turn_n;
         moves_r     <= moves_n;
         org_row_r   <= org_row_n;
         org_col_r   <= org_col_n;
         colour_r    <= colour_n;
         dir_r       <= dir_n;
         k_r         <= k_n;
         count_r     <= count_n;
         busy_r      <= busy_n;
         game_over_r <= game_over_n;
         winner_r    <= winner_n;
         place_rej_r <= place_rej_n;
      end
   end

   assign board     = board_r;
   assign cur_row   = cur_row_r;
   assign cur_col   = cur_col_r;
   assign turn      = turn_r;
   assign busy      = busy_r;
   assign game_over = game_over_r;
   assign winner    = winner_r;
   assign place_rej = place_rej_r;

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Game controller that owns the Gomoku board storage and sequences every write to it. Accepts one-cycle action pulses (cursor moves, place, new game), alternates turns, and rejects placements on occupied cells. After each accepted placement it runs a cycle-by-cycle line scan for a win or a draw. Sits between the button debouncers and the VGA pixel generator, which reads `board` and the cursor outputs combinationally.

## Interface

Parameters:
- `N`, 6: board edge length in cells; the board is N×N.
- `WIN_LEN`, 5: consecutive same-colour stones that win; must be ≤ N.

Ports (`IW = $clog2(N)`):
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `new_game`  in  1  pulse; clears the game in any state.
- `mv_up`, `mv_down`, `mv_left`, `mv_right`  in  1 each  cursor move pulses.
- `place`  in  1  pulse; place the current player's stone at the cursor.
- `board`  out  2 × [N][N]  cell array indexed `[row][col]`; 00 empty, 01 black, 10 white, 11 never driven.
- `cur_row`, `cur_col`  out  IW each  cursor position.
- `turn`  out  1  side to move: 0 black, 1 white.
- `busy`  out  1  high while the scan runs.
- `game_over`  out  1  high in WON or DRAW.
- `winner`  out  2  01 black, 10 white, 00 otherwise (including draw).
- `place_rej`  out  1  one-cycle pulse when `place` hits an occupied cell.

## Operation

- **Reset and `new_game`** (identical effect):
  - All cells 00; cursor (0,0); `turn` 0; `busy` 0; `game_over` 0; `winner` 00; `place_rej` 0; move counter 0; state IDLE.
  - `new_game` overrides every other input and aborts a scan in progress.
- **IDLE**: one action per cycle. Priority is `place` > `mv_up` > `mv_down` > `mv_left` > `mv_right`; lower-priority pulses in that cycle are dropped.
  - Cursor moves wrap: up from row 0 goes to N-1, right from col N-1 goes to 0.
  - `place` on an occupied cell: `place_rej` = 1 next cycle; board and turn unchanged.
  - `place` on an empty cell: write the stone colour (`turn`+1), latch the origin and colour, increment the move counter, go to SCAN_POS with dir = 0, k = 1, count = 1.
- **Scan directions**: dir 0 (0,+1), 1 (+1,0), 2 (+1,+1), 3 (+1,-1). Each cycle probes one cell `origin ± k·(dr,dc)`.
- **SCAN_POS**:
  - In bounds and same colour: count+1, k+1.
  - Otherwise: go to SCAN_NEG with k = 1.
- **SCAN_NEG**: same probe rule, mirrored direction. On a miss:
  - dir < 3: dir+1, k = 1, count = 1, back to SCAN_POS.
  - dir = 3: go to FINISH.
- **Early win**: whenever count reaches WIN_LEN in either scan state, go to WON next cycle. Count saturates at WIN_LEN.
- **FINISH**, one cycle:
  - Move counter = N·N: go to DRAW.
  - Otherwise: toggle `turn`, go to IDLE.
- **WON**: `winner` = latched colour, `game_over` = 1, `turn` frozen.
- **DRAW**: `game_over` = 1, `winner` = 00.
- **Ignored inputs**: in SCAN_*, FINISH, WON and DRAW, all inputs except `new_game` are ignored (no `place_rej`).

## Timing

- All outputs are registered; board writes land on the edge after `place` is sampled.
- `busy` = 1 in SCAN_POS, SCAN_NEG and FINISH, starting the cycle after an accepted `place`.
- Scan latency:
  - Each direction takes (hits_pos+1)+(hits_neg+1) cycles, plus 1 for FINISH.
  - An isolated stone takes 8+1 = 9 cycles from accept to IDLE.
  - Worst case without a win is bounded by 4·(N+1)+1.
- A cursor move is visible on `cur_row`/`cur_col` one cycle after the pulse.
- `place_rej` lasts exactly one cycle.
- `rst` has priority over `new_game`; both take effect at the next edge.

## Structure

- Package `gomoku_pkg`:
  - `cell_t` enum {EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10}.
  - State enum {IDLE, SCAN_POS, SCAN_NEG, FINISH, WON, DRAW}.
  - Direction delta constants `DIR_DR[4]`, `DIR_DC[4]`.
  - Default `N`, `WIN_LEN`.
- Split into top FSM and board storage plus one sub-module, `board_line_probe`: a combinational bounds-check and cell compare for (origin, dir, k, sign, colour) that returns `hit`.
- Probe coordinates use IW+2-bit signed arithmetic so that off-board values (−1, N) are detectable.

## Test plan

- **Reset**: assert `rst` → all cells 00, cursor (0,0), `turn` 0, `game_over` 0, `winner` 00.
- **Cursor wrap and priority**: `mv_up` from (0,0) → (5,0). Then `mv_left` + `mv_right` in the same cycle → (5,5) (left wins).
- **Rejection**: black places at (2,2), scan finishes; white `place` at (2,2) → `place_rej` pulse, cell stays 01, `turn` stays 1.
- **Scan latency**: isolated placement → `busy` high exactly 9 cycles, then `turn` toggles.
- **Diagonal win**: black at (0,0)…(3,3) via interleaved white moves, then (4,4) → `winner` 01, `game_over` 1; later `place` ignored.
- **Abort and draw**: `new_game` during a scan → board cleared next cycle. Fill all 36 cells with no 5-line (test pattern) → DRAW, `winner` 00.
